// File: rtl/rv32_control_unit.sv
// Registered RV32I decoder: turns the fetched instruction word into ALU op, immediate,
// register addresses, load/store sub-ops and enables, all presented one cycle later.
module rv32_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [4:0]  alu_op,
  output logic [11:0] immediate,
  output logic [2:0]  load_operation,
  output logic [2:0]  store_operation,
  output logic        jump,
  output logic [4:0]  reg_read_address1,
  output logic [4:0]  reg_read_address2,
  output logic [4:0]  reg_write_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        reg_read_enable,
  output logic        reg_write_enable,
  output logic        illegal
);

  // No handshake: a fresh decode is registered every cycle, valid one cycle after the
  // instruction is sampled; reset forces the NOP decode.
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [4:0] ALU_NOP  = 5'd31;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign rd     = instruction[11:7];

  logic [4:0]  d_alu;
  logic [11:0] d_imm;
  logic [2:0]  d_ld, d_st;
  logic        d_jump;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_mre, d_mwe, d_rre, d_rwe, d_ill;
  logic        writes_rd;

  always_comb begin
    d_alu     = ALU_NOP;
    d_imm     = 12'd0;
    d_ld      = 3'd0;
    d_st      = 3'd0;
    d_jump    = 1'b0;
    d_rs1     = 5'd0;
    d_rs2     = 5'd0;
    d_rd      = 5'd0;
    d_mre     = 1'b0;
    d_mwe     = 1'b0;
    d_rre     = 1'b0;
    d_rwe     = 1'b0;
    d_ill     = 1'b0;
    writes_rd = 1'b0;

    case (opcode)
      OP_R: begin
        d_rs1     = rs1;
        d_rs2     = rs2;
        d_rd      = rd;
        writes_rd = 1'b1;
        case (funct3)
          3'b000:  d_alu = funct7[5] ? 5'd1 : 5'd0;
          3'b001:  d_alu = 5'd2;
          3'b010:  d_alu = 5'd3;
          3'b011:  d_alu = 5'd4;
          3'b100:  d_alu = 5'd5;
          3'b101:  d_alu = funct7[5] ? 5'd7 : 5'd6;
          3'b110:  d_alu = 5'd8;
          default: d_alu = 5'd9;
        endcase
        // Only SUB and SRA may carry the alternate funct7.
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          d_ill = 1'b1;
      end
      OP_I: begin
        d_rs1     = rs1;
        d_rd      = rd;
        d_imm     = instruction[31:20];
        writes_rd = 1'b1;
        case (funct3)
          3'b000: d_alu = 5'd10;
          3'b010: d_alu = 5'd11;
          3'b011: d_alu = 5'd12;
          3'b100: d_alu = 5'd13;
          3'b110: d_alu = 5'd14;
          3'b111: d_alu = 5'd15;
          3'b001: begin
            d_alu = 5'd16;
            d_imm = {7'd0, rs2};
            if (funct7 != 7'b0000000) d_ill = 1'b1;
          end
          default: begin
            d_alu = instruction[30] ? 5'd18 : 5'd17;
            d_imm = {7'd0, rs2};
            if ({instruction[31], instruction[29:25]} != 6'd0) d_ill = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        d_alu     = 5'd19;
        d_rs1     = rs1;
        d_rd      = rd;
        d_imm     = instruction[31:20];
        d_ld      = funct3;
        d_mre     = 1'b1;
        writes_rd = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_ill = 1'b1;
      end
      OP_STORE: begin
        d_alu = 5'd20;
        d_rs1 = rs1;
        d_rs2 = rs2;
        d_imm = {instruction[31:25], instruction[11:7]};
        d_st  = funct3;
        d_mwe = 1'b1;
        if (funct3 > 3'b010) d_ill = 1'b1;
      end
      OP_JALR: begin
        d_alu     = 5'd21;
        d_rs1     = rs1;
        d_rd      = rd;
        d_imm     = instruction[31:20];
        d_jump    = 1'b1;
        writes_rd = 1'b1;
        if (funct3 != 3'b000) d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase

    // A malformed encoding must not leak any partial decode downstream.
    if (d_ill) begin
      d_alu  = ALU_NOP;
      d_imm  = 12'd0;
      d_ld   = 3'd0;
      d_st   = 3'd0;
      d_jump = 1'b0;
      d_rs1  = 5'd0;
      d_rs2  = 5'd0;
      d_rd   = 5'd0;
      d_mre  = 1'b0;
      d_mwe  = 1'b0;
    end else begin
      d_rre = 1'b1;
      d_rwe = writes_rd && (rd != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op            <= ALU_NOP;
      immediate         <= 12'd0;
      load_operation    <= 3'd0;
      store_operation   <= 3'd0;
      jump              <= 1'b0;
      reg_read_address1 <= 5'd0;
      reg_read_address2 <= 5'd0;
      reg_write_address <= 5'd0;
      mem_read_enable   <= 1'b0;
      mem_write_enable  <= 1'b0;
      reg_read_enable   <= 1'b0;
      reg_write_enable  <= 1'b0;
      illegal           <= 1'b0;
    end else begin
      alu_op            <= d_alu;
      immediate         <= d_imm;
      load_operation    <= d_ld;
      store_operation   <= d_st;
      jump              <= d_jump;
      reg_read_address1 <= d_rs1;
      reg_read_address2 <= d_rs2;
      reg_write_address <= d_rd;
      mem_read_enable   <= d_mre;
      mem_write_enable  <= d_mwe;
      reg_read_enable   <= d_rre;
      reg_write_enable  <= d_rwe;
      illegal           <= d_ill;
    end
  end

endmodule

// File: tb/tb_rv32_control_unit.sv
// Scoreboarded bench for rv32_control_unit: directed instructions with hand-decoded
// expectations queued at issue, checked by an independent monitor one cycle later.
module tb_rv32_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  alu_op;
  logic [11:0] immediate;
  logic [2:0]  load_operation;
  logic [2:0]  store_operation;
  logic        jump;
  logic [4:0]  reg_read_address1;
  logic [4:0]  reg_read_address2;
  logic [4:0]  reg_write_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        reg_read_enable;
  logic        reg_write_enable;
  logic        illegal;

  rv32_control_unit dut (
    .clk               (clk),
    .reset             (reset),
    .instruction       (instruction),
    .alu_op            (alu_op),
    .immediate         (immediate),
    .load_operation    (load_operation),
    .store_operation   (store_operation),
    .jump              (jump),
    .reg_read_address1 (reg_read_address1),
    .reg_read_address2 (reg_read_address2),
    .reg_write_address (reg_write_address),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .reg_read_enable   (reg_read_enable),
    .reg_write_enable  (reg_write_enable),
    .illegal           (illegal)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int W = 44;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         tb_valid;
  int           checks = 0;
  int           passed = 0;

  // Packed order: alu imm ld st jump rs1 rs2 rd mre mwe rre rwe ill
  function automatic logic [W-1:0] pack(input logic [4:0] alu, input logic [11:0] imm,
                                        input logic [2:0] ld, input logic [2:0] st,
                                        input logic jmp, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [4:0] rd,
                                        input logic mre, input logic mwe,
                                        input logic rre, input logic rwe,
                                        input logic ill);
    return {alu, imm, ld, st, jmp, r1, r2, rd, mre, mwe, rre, rwe, ill};
  endfunction

  function automatic logic [W-1:0] reset_exp();
    return pack(5'd31, 12'h0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] ill_exp();
    return pack(5'd31, 12'h0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Driver task: one instruction per cycle, applied on the falling edge.
  task automatic drive(input logic rst, input logic [31:0] instr,
                       input logic [W-1:0] exp, input string name);
    @(negedge clk);
    reset       = rst;
    instruction = instr;
    tb_valid    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // Monitor / scoreboard
  always begin
    logic         v;
    logic [W-1:0] act, exp;
    string        nm;
    @(posedge clk);
    v = tb_valid;
    #1;
    if (v) begin
      act = {alu_op, immediate, load_operation, store_operation, jump, reg_read_address1,
             reg_read_address2, reg_write_address, mem_read_enable, mem_write_enable,
             reg_read_enable, reg_write_enable, illegal};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow actual=%h required=<queued entry>", act);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
    end
  end

  initial begin
    tb_valid    = 1'b0;
    reset       = 1'b1;
    instruction = 32'h0;

    drive(1'b1, 32'h002081B3, reset_exp(), "reset_state");
    drive(1'b0, 32'h002081B3, pack(5'd0, 12'h0, 3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "add");
    drive(1'b0, 32'h407302B3, pack(5'd1, 12'h0, 3'd0, 3'd0, 1'b0, 5'd6, 5'd7, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "sub");
    drive(1'b0, 32'h4020D1B3, pack(5'd7, 12'h0, 3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "sra");
    drive(1'b0, 32'h0020F1B3, pack(5'd9, 12'h0, 3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "and");
    drive(1'b0, 32'h4020C1B3, ill_exp(), "r_bad_funct7");
    drive(1'b0, 32'hFFF00093, pack(5'd10, 12'hFFF, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "addi_neg");
    drive(1'b0, 32'h00000013, pack(5'd10, 12'h0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "nop_rd0");
    drive(1'b0, 32'hFFF13093, pack(5'd12, 12'hFFF, 3'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "sltiu");
    drive(1'b0, 32'h40315093, pack(5'd18, 12'h003, 3'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "srai");
    drive(1'b0, 32'h00315093, pack(5'd17, 12'h003, 3'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "srli");
    drive(1'b0, 32'h40311093, ill_exp(), "slli_bad_funct7");
    drive(1'b0, 32'hC0315093, ill_exp(), "srai_bad_bit31");
    drive(1'b0, 32'h00812203, pack(5'd19, 12'h008, 3'd2, 3'd0, 1'b0, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "lw");
    drive(1'b0, 32'h00814203, pack(5'd19, 12'h008, 3'd4, 3'd0, 1'b0, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "lbu");
    drive(1'b0, 32'h00813203, ill_exp(), "load_bad_funct3");
    drive(1'b0, 32'h00512623, pack(5'd20, 12'h00C, 3'd0, 3'd2, 1'b0, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "sw");
    drive(1'b0, 32'hFE512E23, pack(5'd20, 12'hFFC, 3'd0, 3'd2, 1'b0, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "sw_neg_imm");
    drive(1'b0, 32'h00510623, pack(5'd20, 12'h00C, 3'd0, 3'd0, 1'b0, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "sb");
    drive(1'b0, 32'h00513623, ill_exp(), "store_bad_funct3");
    drive(1'b0, 32'h000280E7, pack(5'd21, 12'h0, 3'd0, 3'd0, 1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "jalr");
    drive(1'b0, 32'h000290E7, ill_exp(), "jalr_bad_funct3");
    drive(1'b0, 32'hFFFFFFFF, ill_exp(), "all_ones");
    drive(1'b0, 32'h002081B3, pack(5'd0, 12'h0, 3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "add_before_reset");
    drive(1'b1, 32'h407302B3, reset_exp(), "reset_mid_stream");
    drive(1'b0, 32'h00812203, pack(5'd19, 12'h008, 3'd2, 3'd0, 1'b0, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "lw_after_reset");

    @(negedge clk);
    tb_valid = 1'b0;
    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() != 0) begin
        checks++;
        $display("FAIL drain_timeout actual=%0d pending required=0 pending", exp_q.size());
      end
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
